// File: rtl/flit_send_arbiter.sv
// Credit-aware round-robin scheduler sharing one network send port among NUM_REQ requesters.
// Define FLIT_SEND_ARB_PACKET_LOCK_EN for packet-atomic grants; otherwise flits interleave freely.
module flit_send_arbiter #(
  parameter int unsigned FLIT_WIDTH = 64,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned NUM_VCS    = 2,
  parameter int unsigned CREDITS    = 8,
  localparam int unsigned VC_BITS   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ*VC_BITS-1:0]    req_vc,
  input  logic [NUM_REQ-1:0]            req_tail,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [FLIT_WIDTH-1:0]         send_putFlit_flit_in,
  output logic                          EN_send_putFlit,
  input  logic [VC_BITS:0]              send_getCredits,
  output logic                          EN_send_getCredits,
  output logic                          credit_err,
  output logic                          locked
);

  localparam int unsigned CW  = $clog2(CREDITS + 1);
  localparam int unsigned PW  = $clog2(NUM_REQ);
  localparam int unsigned NVP = 1 << VC_BITS;

  logic [CW-1:0]        crQ [NUM_VCS];
  logic [CW-1:0]        crD [NUM_VCS];
  logic [PW-1:0]        rrPtrQ, rrPtrD, nextPtr;
  logic                 creditErrQ, creditErrD;
  logic [NUM_REQ-1:0]   reqHasCredit, ownerMask, eligible;
  logic                 grantValid, fire, grantTail;
  logic [PW-1:0]        grantIdx;
  logic [VC_BITS-1:0]   grantVc, retVc;
  logic                 retValid;
  logic [NVP-1:0]       vcInRange;
  logic [NUM_VCS-1:0]   vcConsume, vcReturn;

  // A requester targeting a VC that does not exist never sees a credit.
  always_comb begin
    reqHasCredit = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        if (req_vc[i*VC_BITS +: VC_BITS] == VC_BITS'(v) && crQ[v] != '0) begin
          reqHasCredit[i] = 1'b1;
        end
      end
    end
  end

`ifdef FLIT_SEND_ARB_PACKET_LOCK_EN
  typedef enum logic [0:0] {StIdle, StLocked} arbStateT;
  arbStateT      stateQ, stateD;
  logic [PW-1:0] ownerQ, ownerD;

  always_comb begin
    ownerMask = '1;
    if (stateQ == StLocked) begin
      ownerMask         = '0;
      ownerMask[ownerQ] = 1'b1;
    end
  end
`else
  assign ownerMask = '1;
`endif

  assign eligible = req_valid & reqHasCredit & ownerMask;

  // Search starts at rrPtrQ and wraps; the first eligible requester wins.
  always_comb begin
    int unsigned idx;
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rrPtrQ) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grantValid && eligible[idx]) begin
        grantValid = 1'b1;
        grantIdx   = PW'(idx);
      end
    end
  end

  assign fire    = grantValid & ~RST;
  assign nextPtr = (grantIdx == PW'(NUM_REQ - 1)) ? '0 : grantIdx + PW'(1);

  always_comb begin
    req_ready            = '0;
    send_putFlit_flit_in = '0;
    grantVc              = '0;
    grantTail            = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (fire && grantIdx == PW'(i)) begin
        req_ready[i]         = 1'b1;
        send_putFlit_flit_in = req_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        grantVc              = req_vc[i*VC_BITS +: VC_BITS];
        grantTail            = req_tail[i];
      end
    end
  end

  assign EN_send_putFlit    = fire;
  assign EN_send_getCredits = ~RST;
  assign retValid           = send_getCredits[VC_BITS] & ~RST;
  assign retVc              = send_getCredits[VC_BITS-1:0];

  always_comb begin
    for (int unsigned v = 0; v < NVP; v++) vcInRange[v] = (v < NUM_VCS);
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      vcConsume[v] = fire && (grantVc == VC_BITS'(v));
      vcReturn[v]  = retValid && (retVc == VC_BITS'(v));
    end
  end

  // A consume and a return on the same VC cancel out, so saturation cannot trip there.
  always_comb begin
    creditErrD = creditErrQ;
    if (retValid && !vcInRange[retVc]) creditErrD = 1'b1;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      crD[v] = crQ[v];
      if (vcConsume[v] && !vcReturn[v]) begin
        crD[v] = crQ[v] - CW'(1);
      end else if (vcReturn[v] && !vcConsume[v]) begin
        if (crQ[v] == CW'(CREDITS)) creditErrD = 1'b1;
        else crD[v] = crQ[v] + CW'(1);
      end
    end
  end

`ifdef FLIT_SEND_ARB_PACKET_LOCK_EN
  always_comb begin
    stateD = stateQ;
    ownerD = ownerQ;
    rrPtrD = rrPtrQ;
    if (fire) begin
      case (stateQ)
        StIdle: begin
          if (grantTail) begin
            rrPtrD = nextPtr;
          end else begin
            stateD = StLocked;
            ownerD = grantIdx;
          end
        end
        StLocked: begin
          // Only the owner can fire here, so nextPtr is owner+1.
          if (grantTail) begin
            stateD = StIdle;
            rrPtrD = nextPtr;
          end
        end
        default: stateD = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stateQ <= StIdle;
      ownerQ <= '0;
    end else begin
      stateQ <= stateD;
      ownerQ <= ownerD;
    end
  end

  assign locked = (stateQ == StLocked);
`else
  logic unusedTail;
  assign unusedTail = grantTail;
  assign rrPtrD     = fire ? nextPtr : rrPtrQ;
  assign locked     = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned v = 0; v < NUM_VCS; v++) crQ[v] <= CW'(CREDITS);
      rrPtrQ     <= '0;
      creditErrQ <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NUM_VCS; v++) crQ[v] <= crD[v];
      rrPtrQ     <= rrPtrD;
      creditErrQ <= creditErrD;
    end
  end

  assign credit_err = creditErrQ;

endmodule

// File: doc/flit_send_arbiter.md
# flit_send_arbiter

Credit-aware scheduler that shares one network send port among NUM_REQ flit requesters, such as AXI4 master/slave bridges or their input FIFOs. It sits between the requesters' put_flit valid/ready streams and the mkNetwork `send_ports_N_putFlit` / `send_ports_N_getCredits` pair. It tracks per-VC credits and grants round-robin, packet-atomically. It never sends a flit without a credit for that flit's VC.

## Interface
- FLIT_WIDTH, 64: network flit width; bit FLIT_WIDTH-1 is the flit valid bit.
- NUM_REQ, 4: number of requesters (2..8).
- NUM_VCS, 2: virtual channels; VC_BITS = max(1, $clog2(NUM_VCS)).
- CREDITS, 8: initial/maximum credits per VC (1..15); counter width CW = $clog2(CREDITS+1).
- CLK  in  1  clock, all state on posedge.
- RST  in  1  asynchronous, active-high reset.
- req_flit  in  NUM_REQ*FLIT_WIDTH  requester flits, requester i at slice i.
- req_vc  in  NUM_REQ*VC_BITS  target VC per requester.
- req_tail  in  NUM_REQ  flit is last of its packet.
- req_valid  in  NUM_REQ  requester has a flit.
- req_ready  out  NUM_REQ  flit accepted this cycle (fire = valid & ready).
- send_putFlit_flit_in  out  FLIT_WIDTH  granted flit, unmodified.
- EN_send_putFlit  out  1  network enqueue strobe.
- send_getCredits  in  VC_BITS+1  credit return; MSB valid, low bits VC.
- EN_send_getCredits  out  1  credit dequeue strobe.
- credit_err  out  1  sticky: credit returned to a full counter.
- locked  out  1  a packet is in flight (owner held).

## Operation
- Credit counters cr[v], one per VC. Reset to CREDITS.
- Eligible(i) = req_valid[i] & cr[req_vc[i]] != 0 & (!locked | owner == i).
- Grant: first eligible requester at or after rr_ptr, wrapping modulo NUM_REQ. Only one grant per cycle.
- On grant g, req_ready[g] = 1, EN_send_putFlit = 1, and send_putFlit_flit_in = req_flit[g]. When there is no grant, the flit output is all-zero (valid bit 0).
- State IDLE (locked=0) -> LOCKED when a fire has req_tail=0. Record owner = g.
- State LOCKED -> IDLE when owner fires with req_tail=1. Set rr_ptr = owner+1 (mod NUM_REQ).
- A single-flit packet (tail on first flit) stays in IDLE and sets rr_ptr = g+1.
- In LOCKED, only the owner is eligible. If the owner is invalid or out of credit, the port idles. Other requesters are never granted.
- EN_send_getCredits = 1 whenever not in reset; credits are pulled every cycle.
- On valid return to VC v: cr[v] += 1. If cr[v] == CREDITS, the counter saturates and credit_err is set until reset.
- Simultaneous consume and return on the same VC leaves cr[v] unchanged. There is no error, even at CREDITS.
- A return VC index >= NUM_VCS is ignored and sets credit_err.
- Flit content is never inspected or modified. The requester owns VC/tail consistency.

## Timing
- Zero-cycle grant: req_ready and EN_send_putFlit are combinational from req_valid, req_vc, and registered state.
- Counters, owner, rr_ptr, locked, and credit_err update at the posedge after a fire or return.
- A credit returned in cycle t is usable in cycle t+1.
- The last credit consumed in cycle t makes that VC ineligible from t+1.
- Throughput: 1 flit/cycle while credits remain.
- While RST is high: req_ready=0, EN_send_putFlit=0, EN_send_getCredits=0, flit_in=0, locked=0, credit_err=0, rr_ptr=0, cr[*]=CREDITS.
- Reset asserted mid-packet drops the lock immediately. No partial-packet recovery is performed; the upstream is reset together with this block.

## Configuration
- FLIT_SEND_ARB_PACKET_LOCK_EN defined: packet-atomic grant as described (IDLE/LOCKED FSM).
- Not defined: flit-level round robin. locked is tied to 0, rr_ptr = g+1 after every fire, and packets from different requesters may interleave. Use this only where every flit carries full routing info.

## Test plan
- Reset release, NUM_REQ=4, CREDITS=8, requester 0 sends 3 single-flit packets on VC0 with no returns -> 3 fires on consecutive cycles; cr[0]=5.
- Requesters 0..3 all valid continuously, single-flit packets, credits returned every cycle -> grant order 0,1,2,3,0,1; one EN_send_putFlit per cycle.
- LOCK_EN: requester 1 sends a 4-flit packet while requester 2 is valid -> flits 1,1,1,1, then 2; locked=1 from the cycle after the first fire until the cycle after the tail.
- VC0 credits exhausted (8 fires, no returns), requester 0 on VC0, requester 1 on VC1 -> requester 0 stalls, requester 1 granted; a VC0 return at cycle t lets requester 0 fire at t+1.
- Return to VC1 while cr[1]=8 and no send -> cr[1] stays 8 and credit_err=1. Same return coinciding with a VC1 fire -> cr[1]=8 and credit_err stays 0.
- RST asserted mid-packet (after 2 of 4 flits) -> outputs 0 asynchronously; after release locked=0, cr[*]=8, and a new packet from requester 3 is granted on the first valid cycle.
